// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the SRAM window arbiter.
// Port indices double as the 'last' encoding used by the round-robin picker.
package nano_bus_pkg;

    localparam int DATA_W = 9;
    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sram_arbiter_pick.sv
// Two-way round-robin picker: a lone requester wins outright,
// a tie goes to the port that did not own the SRAM last.
module rr_pick2
    import nano_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = (last == PORT_DMA) ? PORT_CPU : PORT_DMA;
        if (req == 2'b01) begin
            winner = PORT_CPU;
        end else if (req == 2'b10) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port 128x9 SRAM between the processor (port 0) and the loader/DMA (port 1):
// round-robin ownership with bounded bursts, registered SRAM command, fixed-latency read strobe.
module sram_arbiter #(
    parameter int DATA_W    = nano_bus_pkg::DATA_W,
    parameter int ADDR_W    = nano_bus_pkg::ADDR_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              sram_wre,
    output logic [ADDR_W-1:0] sram_ad,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);
    import nano_bus_pkg::*;

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_t        state, state_nxt;
    logic              last, last_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              accept0, accept1, accept;
    logic              wr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [1:0]        pick_req;
    logic              pick_winner, pick_any;
    logic              burst_done;
    logic              rd_v1, rd_p1, rd_v2, rd_p2;

    assign gnt0    = (state == OWN0);
    assign gnt1    = (state == OWN1);
    assign accept0 = req0 & gnt0;
    assign accept1 = req1 & gnt1;
    assign accept  = accept0 | accept1;

    assign wr_sel    = accept1 ? wr1    : wr0;
    assign addr_sel  = accept1 ? addr1  : addr0;
    assign wdata_sel = accept1 ? wdata1 : wdata0;

    // While owning, only the other port is offered to the picker, so 'any' means a handover target exists.
    always_comb begin
        pick_req = '0;
        unique case (state)
            IDLE:    pick_req = {req1, req0};
            OWN0:    pick_req = {req1, 1'b0};
            OWN1:    pick_req = {1'b0, req0};
            default: pick_req = '0;
        endcase
    end

    rr_pick2 u_pick (
        .req    (pick_req),
        .last   (last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign burst_done = (count == CNT_MAX);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                count_nxt = '0;
                if (pick_any) begin
                    state_nxt = (pick_winner == PORT_DMA) ? OWN1 : OWN0;
                end
            end
            OWN0, OWN1: begin
                if (!accept) begin
                    state_nxt = pick_any ? ((state == OWN0) ? OWN1 : OWN0) : IDLE;
                    count_nxt = '0;
                end else if (burst_done && pick_any) begin
                    state_nxt = (state == OWN0) ? OWN1 : OWN0;
                    count_nxt = '0;
                end else if (!burst_done) begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
        if (accept) begin
            last_nxt = accept1 ? PORT_DMA : PORT_CPU;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            last     <= PORT_DMA;
            count    <= '0;
            sram_wre <= 1'b0;
            sram_ad  <= '0;
            sram_din <= '0;
            rd_v1    <= 1'b0;
            rd_p1    <= 1'b0;
            rd_v2    <= 1'b0;
            rd_p2    <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            count    <= count_nxt;
            sram_wre <= accept & wr_sel;
            if (accept) begin
                sram_ad  <= addr_sel;
                sram_din <= wdata_sel;
            end
            rd_v1 <= accept & ~wr_sel;
            rd_p1 <= accept1;
            rd_v2 <= rd_v1;
            rd_p2 <= rd_p1;
        end
    end

    assign rvalid0 = rd_v2 & ~rd_p2;
    assign rvalid1 = rd_v2 & rd_p2;
    assign rdata   = sram_dout;

endmodule
